// File: rtl/hsv2rgb_pkg.sv
// Shared types and constants for the HSV-to-RGB pipeline: pixel field
// widths, hue sector encoding, field slice positions and the exact
// divide-by-255 helper used by every multiplier stage.
package hsv2rgb_pkg;

  localparam int PIX_W    = 8;
  localparam int HSV_W    = 24;
  localparam int SECTOR_W = 3;

  // Hue circle split into six 60-degree sectors, named by the two primaries
  // or secondaries that bound each one.
  typedef enum logic [SECTOR_W-1:0] {
    SEC_R_Y = 3'd0,
    SEC_Y_G = 3'd1,
    SEC_G_C = 3'd2,
    SEC_C_B = 3'd3,
    SEC_B_M = 3'd4,
    SEC_M_R = 3'd5
  } sector_e;

  // Field positions inside the 24-bit {H,S,V} input word.
  localparam int H_MSB = 23;
  localparam int H_LSB = 16;
  localparam int S_MSB = 15;
  localparam int S_LSB = 8;
  localparam int V_MSB = 7;
  localparam int V_LSB = 0;

  // Field positions inside the 24-bit {R,G,B} output word.
  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  // Exact floor(x/255) for x in 0..65025. The 17-bit sum never carries into
  // bit 16 for that range, so the quotient fits in 8 bits.
  function automatic logic [PIX_W-1:0] div255(input logic [15:0] x);
    logic [16:0] sum;
    sum = {1'b0, x} + 17'd1 + {9'd0, x[15:8]};
    return PIX_W'(sum >> 8);
  endfunction

endpackage

// File: rtl/hsv2rgb_pipe_mul_div255.sv
// Combinational 8x8 multiply followed by an exact divide by 255.
// Purely combinational; the parent pipeline registers the result.
module mul_div255
  import hsv2rgb_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] y
);

  logic [15:0] prod;

  // Full-precision product, then scale back to 8 bits.
  always_comb begin
    prod = {8'd0, a} * {8'd0, b};
    y    = div255(prod);
  end

endmodule

// File: rtl/hsv2rgb_pipe.sv
// Four-stage HSV-to-RGB converter, one pixel per clock.
//   Stage 1: hue -> sector and fractional position, S/V forwarded.
//   Stage 2: saturation-weighted fractions.
//   Stage 3: value-scaled p/q/t terms.
//   Stage 4: per-sector channel selection.
// Valid and sideband bits travel in lockstep through the same stages.
// Optional macro HSV2RGB_STALL_EN adds out_ready/in_ready back-pressure;
// without it the pipeline is free-running.
module hsv2rgb_pipe
  import hsv2rgb_pkg::*;
#(
  parameter int SB_W    = 3,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HSV_W-1:0] hsv_in,
  input  logic             in_valid,
  input  logic [SB_W-1:0]  sb_in,
  output logic [HSV_W-1:0] rgb_out,
  output logic             out_valid,
  output logic [SB_W-1:0]  sb_out
`ifdef HSV2RGB_STALL_EN
  ,
  input  logic             out_ready,
  output logic             in_ready
`endif
);

  // Pipeline advance enable: every stage register moves together or holds.
  logic adv;

`ifdef HSV2RGB_STALL_EN
  // An empty output slot can always be overwritten; a full one only when
  // the consumer takes it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
`else
  assign adv = 1'b1;
`endif

  // ---------------------------------------------------------------- stage 1
  logic [10:0]      hx;
  sector_e          sec1_q, sec1_d;
  logic [PIX_W-1:0] f1_q, f1_d;
  logic [PIX_W-1:0] s1_q, s1_d;
  logic [PIX_W-1:0] v1_q, v1_d;

  // Stage 1: scale hue by six to split it into sector and fraction.
  // NOTE: every always_comb output gets a hold/default value before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    sec1_d = sec1_q;
    f1_d   = f1_q;
    s1_d   = s1_q;
    v1_d   = v1_q;
    hx     = {3'd0, hsv_in[H_MSB:H_LSB]} * 11'd6;
    if (adv) begin
      sec1_d = sector_e'(hx[10:8]);
      f1_d   = hx[7:0];
      s1_d   = hsv_in[S_MSB:S_LSB];
      v1_d   = hsv_in[V_MSB:V_LSB];
    end
  end

  // Stage 1 registers.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec1_q <= SEC_R_Y;
      f1_q   <= '0;
      s1_q   <= '0;
      v1_q   <= '0;
    end else begin
      sec1_q <= sec1_d;
      f1_q   <= f1_d;
      s1_q   <= s1_d;
      v1_q   <= v1_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [PIX_W-1:0] f1_inv;
  logic [PIX_W-1:0] sf_calc, sfn_calc;
  sector_e          sec2_q, sec2_d;
  logic [PIX_W-1:0] sf2_q, sf2_d;
  logic [PIX_W-1:0] sfn2_q, sfn2_d;
  logic [PIX_W-1:0] sc2_q, sc2_d;
  logic [PIX_W-1:0] v2_q, v2_d;

  assign f1_inv = 8'd255 - f1_q;

  mul_div255 u_sf (
    .a (s1_q),
    .b (f1_q),
    .y (sf_calc)
  );

  mul_div255 u_sfn (
    .a (s1_q),
    .b (f1_inv),
    .y (sfn_calc)
  );

  // Stage 2: saturation-weighted rising/falling fractions and 255-S.
  always_comb begin
    sec2_d = sec2_q;
    sf2_d  = sf2_q;
    sfn2_d = sfn2_q;
    sc2_d  = sc2_q;
    v2_d   = v2_q;
    if (adv) begin
      sec2_d = sec1_q;
      sf2_d  = sf_calc;
      sfn2_d = sfn_calc;
      sc2_d  = 8'd255 - s1_q;
      v2_d   = v1_q;
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec2_q <= SEC_R_Y;
      sf2_q  <= '0;
      sfn2_q <= '0;
      sc2_q  <= '0;
      v2_q   <= '0;
    end else begin
      sec2_q <= sec2_d;
      sf2_q  <= sf2_d;
      sfn2_q <= sfn2_d;
      sc2_q  <= sc2_d;
      v2_q   <= v2_d;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [PIX_W-1:0] sf2_inv, sfn2_inv;
  logic [PIX_W-1:0] p_calc, q_calc, t_calc;
  sector_e          sec3_q, sec3_d;
  logic [PIX_W-1:0] p3_q, p3_d;
  logic [PIX_W-1:0] q3_q, q3_d;
  logic [PIX_W-1:0] t3_q, t3_d;
  logic [PIX_W-1:0] v3_q, v3_d;

  assign sf2_inv  = 8'd255 - sf2_q;
  assign sfn2_inv = 8'd255 - sfn2_q;

  mul_div255 u_p (
    .a (v2_q),
    .b (sc2_q),
    .y (p_calc)
  );

  mul_div255 u_q (
    .a (v2_q),
    .b (sf2_inv),
    .y (q_calc)
  );

  mul_div255 u_t (
    .a (v2_q),
    .b (sfn2_inv),
    .y (t_calc)
  );

  // Stage 3: value-scaled floor (p), falling (q) and rising (t) channels.
  always_comb begin
    sec3_d = sec3_q;
    p3_d   = p3_q;
    q3_d   = q3_q;
    t3_d   = t3_q;
    v3_d   = v3_q;
    if (adv) begin
      sec3_d = sec2_q;
      p3_d   = p_calc;
      q3_d   = q_calc;
      t3_d   = t_calc;
      v3_d   = v2_q;
    end
  end

  // Stage 3 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec3_q <= SEC_R_Y;
      p3_q   <= '0;
      q3_q   <= '0;
      t3_q   <= '0;
      v3_q   <= '0;
    end else begin
      sec3_q <= sec3_d;
      p3_q   <= p3_d;
      q3_q   <= q3_d;
      t3_q   <= t3_d;
      v3_q   <= v3_d;
    end
  end

  // ---------------------------------------------------------------- stage 4
  logic [HSV_W-1:0] rgb_sel;
  logic [HSV_W-1:0] rgb4_q, rgb4_d;

  // Stage 4: route V/p/q/t onto R/G/B according to the hue sector.
  always_comb begin
    rgb_sel = {v3_q, v3_q, v3_q};
    rgb4_d  = rgb4_q;
    unique case (sec3_q)
      SEC_R_Y: begin
        rgb_sel[R_MSB:R_LSB] = v3_q;
        rgb_sel[G_MSB:G_LSB] = t3_q;
        rgb_sel[B_MSB:B_LSB] = p3_q;
      end
      SEC_Y_G: begin
        rgb_sel[R_MSB:R_LSB] = q3_q;
        rgb_sel[G_MSB:G_LSB] = v3_q;
        rgb_sel[B_MSB:B_LSB] = p3_q;
      end
      SEC_G_C: begin
        rgb_sel[R_MSB:R_LSB] = p3_q;
        rgb_sel[G_MSB:G_LSB] = v3_q;
        rgb_sel[B_MSB:B_LSB] = t3_q;
      end
      SEC_C_B: begin
        rgb_sel[R_MSB:R_LSB] = p3_q;
        rgb_sel[G_MSB:G_LSB] = q3_q;
        rgb_sel[B_MSB:B_LSB] = v3_q;
      end
      SEC_B_M: begin
        rgb_sel[R_MSB:R_LSB] = t3_q;
        rgb_sel[G_MSB:G_LSB] = p3_q;
        rgb_sel[B_MSB:B_LSB] = v3_q;
      end
      SEC_M_R: begin
        rgb_sel[R_MSB:R_LSB] = v3_q;
        rgb_sel[G_MSB:G_LSB] = p3_q;
        rgb_sel[B_MSB:B_LSB] = q3_q;
      end
      default: rgb_sel = {v3_q, v3_q, v3_q};
    endcase
    if (adv) begin
      rgb4_d = rgb_sel;
    end
  end

  // Stage 4 register drives the colour output directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb4_q <= '0;
    end else begin
      rgb4_q <= rgb4_d;
    end
  end

  // ------------------------------------------------------ valid / sideband
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [SB_W-1:0]    sb_q [LATENCY];
  logic [SB_W-1:0]    sb_d [LATENCY];

  // Valid and sideband shift through LATENCY slots in step with the data.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < LATENCY; i++) begin
      sb_d[i] = sb_q[i];
    end
    if (adv) begin
      valid_d = {valid_q[LATENCY-2:0], in_valid};
      sb_d[0] = sb_in;
      for (int i = 1; i < LATENCY; i++) begin
        sb_d[i] = sb_q[i-1];
      end
    end
  end

  // Valid and sideband delay registers.
  // NOTE: the sideband delay line is a small register array that must read
  // as zero after reset, so each entry is cleared explicitly; a RAM-style
  // array without reset would leak stale sync bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      sb_q    <= sb_d;
    end
  end

  assign rgb_out   = rgb4_q;
  assign out_valid = valid_q[LATENCY-1];
  assign sb_out    = sb_q[LATENCY-1];

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Directed bench for hsv2rgb_pipe. Inputs change and outputs are sampled on
// the falling edge; a pixel driven at one falling edge appears at the fourth
// falling edge after it. Define HSV2RGB_STALL_EN to also cover back-pressure.
module tb_hsv2rgb_pipe;

  localparam int SB_W = 3;
  localparam logic [2:0] SB_VSYNC = 3'b010;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] hsv_in;
  logic        in_valid;
  logic [2:0]  sb_in;
  logic [23:0] rgb_out;
  logic        out_valid;
  logic [2:0]  sb_out;
`ifdef HSV2RGB_STALL_EN
  logic        out_ready;
  logic        in_ready;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hsv2rgb_pipe #(.SB_W(SB_W), .LATENCY(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hsv_in    (hsv_in),
    .in_valid  (in_valid),
    .sb_in     (sb_in),
    .rgb_out   (rgb_out),
    .out_valid (out_valid),
    .sb_out    (sb_out)
`ifdef HSV2RGB_STALL_EN
    ,
    .out_ready (out_ready),
    .in_ready  (in_ready)
`endif
  );

  task automatic drive(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                       input logic vld, input logic [2:0] sb);
    hsv_in   = {h, s, v};
    in_valid = vld;
    sb_in    = sb;
  endtask

  task automatic drain();
    drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    repeat (5) @(negedge clk);
  endtask

  // Reference colours computed by hand from the HSV formulas.
  logic [7:0]  pal_h   [8] = '{8'd0,  8'd128, 8'd43,  8'd255, 8'd10,  8'd170, 8'd77,  8'd200};
  logic [7:0]  pal_s   [8] = '{8'd255,8'd255, 8'd255, 8'd255, 8'd0,   8'd255, 8'd200, 8'd0};
  logic [7:0]  pal_v   [8] = '{8'd255,8'd255, 8'd255, 8'd255, 8'd128, 8'd255, 8'd0,   8'd64};
  logic [23:0] pal_rgb [8] = '{24'hFF0000, 24'h00FFFF, 24'hFDFF00, 24'hFF0005,
                               24'h808080, 24'h0003FF, 24'h000000, 24'h404040};

  task automatic test_reset();
    rst = 1'b1;
    drive(8'd50, 8'd200, 8'd180, 1'b1, 3'b111);
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || rgb_out !== 24'h0 || sb_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b rgb=%06h sb=%03b, expected 0/000000/000",
               out_valid, rgb_out, sb_out);
    end
    rst = 1'b0;
    drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    repeat (5) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_capture: got valid=%b, expected 0", out_valid);
    end
  endtask

  // Single isolated pixels: exactly four cycles, and not three.
  task automatic test_colors();
    for (int k = 0; k < 4; k++) begin
      drive(pal_h[k], pal_s[k], pal_v[k], 1'b1, 3'd0);
      @(negedge clk);
      drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
      repeat (2) @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL color%0d_early: got valid=%b at 3 cycles, expected 0", k, out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || rgb_out !== pal_rgb[k]) begin
        tests_failed++;
        $display("FAIL color%0d: got valid=%b rgb=%06h, expected 1/%06h",
                 k, out_valid, rgb_out, pal_rgb[k]);
      end
    end
    drain();
  endtask

  // Zero saturation: grey at V for every hue.
  task automatic test_grey();
    for (int i = 0; i < 260; i++) begin
      if (i >= 4) begin
        tests_run++;
        if (out_valid !== 1'b1 || rgb_out !== 24'h808080) begin
          tests_failed++;
          $display("FAIL grey_h%0d: got valid=%b rgb=%06h, expected 1/808080",
                   i - 4, out_valid, rgb_out);
        end
      end
      if (i < 256) drive(8'(i), 8'd0, 8'd128, 1'b1, 3'd0);
      else         drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
      @(negedge clk);
    end
    drain();
  endtask

  // Zero value: black regardless of hue and saturation.
  task automatic test_black();
    logic [7:0] bh [4] = '{8'd0, 8'd60, 8'd140, 8'd255};
    logic [7:0] bs [4] = '{8'd255, 8'd17, 8'd128, 8'd0};
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) begin
        tests_run++;
        if (out_valid !== 1'b1 || rgb_out !== 24'h000000) begin
          tests_failed++;
          $display("FAIL black%0d: got valid=%b rgb=%06h, expected 1/000000",
                   i - 4, out_valid, rgb_out);
        end
      end
      if (i < 4) drive(bh[i], bs[i], 8'd0, 1'b1, 3'd0);
      else       drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
      @(negedge clk);
    end
    drain();
  endtask

  // Valid pattern 1,1,0,1 with vsync on the invalid third slot.
  task automatic test_timing();
    logic        tv  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  tsb [5] = '{3'b000, 3'b000, SB_VSYNC, 3'b000, 3'b000};
    int          tp  [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 9; i++) begin
      if (i < 4) begin
        tests_run++;
        if (out_valid !== 1'b0 || sb_out !== 3'b000) begin
          tests_failed++;
          $display("FAIL timing_pre%0d: got valid=%b sb=%03b, expected 0/000",
                   i, out_valid, sb_out);
        end
      end else begin
        tests_run++;
        if (out_valid !== tv[i-4] || sb_out !== tsb[i-4]) begin
          tests_failed++;
          $display("FAIL timing_slot%0d: got valid=%b sb=%03b, expected %b/%03b",
                   i - 4, out_valid, sb_out, tv[i-4], tsb[i-4]);
        end
        if (tv[i-4]) begin
          tests_run++;
          if (rgb_out !== pal_rgb[tp[i-4]]) begin
            tests_failed++;
            $display("FAIL timing_rgb%0d: got %06h, expected %06h",
                     i - 4, rgb_out, pal_rgb[tp[i-4]]);
          end
        end
      end
      if (i < 5) drive(pal_h[tp[i]], pal_s[tp[i]], pal_v[tp[i]], tv[i], tsb[i]);
      else       drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
      @(negedge clk);
    end
    drain();
  endtask

  // Eight consecutive pixels: eight consecutive valid outputs, in order.
  task automatic test_back_to_back();
    int run_len = 0;
    for (int i = 0; i < 13; i++) begin
      if (i >= 4 && i < 12) begin
        tests_run++;
        if (out_valid !== 1'b1 || rgb_out !== pal_rgb[i-4] || sb_out !== 3'(i - 4)) begin
          tests_failed++;
          $display("FAIL b2b%0d: got valid=%b rgb=%06h sb=%0d, expected 1/%06h/%0d",
                   i - 4, out_valid, rgb_out, sb_out, pal_rgb[i-4], (i - 4) % 8);
        end
        if (out_valid === 1'b1) run_len++;
      end
      if (i < 8) drive(pal_h[i], pal_s[i], pal_v[i], 1'b1, 3'(i));
      else       drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
      @(negedge clk);
    end
    tests_run++;
    if (run_len != 8) begin
      tests_failed++;
      $display("FAIL b2b_throughput: got %0d valid beats, expected 8", run_len);
    end
    drain();
  endtask

  // Reset with three pixels in flight: nothing may emerge afterwards.
  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      drive(8'd0, 8'd255, 8'd255, 1'b1, 3'b101);
      @(negedge clk);
    end
    rst = 1'b1;
    drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || rgb_out !== 24'h0 || sb_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL midreset_clear: got valid=%b rgb=%06h sb=%03b, expected 0/000000/000",
               out_valid, rgb_out, sb_out);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || sb_out !== 3'b000) begin
        tests_failed++;
        $display("FAIL midreset_stale%0d: got valid=%b sb=%03b, expected 0/000",
                 i, out_valid, sb_out);
      end
    end
  endtask

`ifdef HSV2RGB_STALL_EN
  // Six pixels, consumer stalls for two cycles while the first is at the output.
  task automatic test_stall();
    int          tx = 0;
    int          rx = 0;
    logic [23:0] held_rgb = '0;
    logic [2:0]  held_sb  = '0;
    for (int c = 0; c < 40 && rx < 6; c++) begin
      out_ready = !(c == 4 || c == 5);
      #1;
      if (!out_ready) begin
        tests_run++;
        if (in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_in_ready_c%0d: got %b, expected 0", c, in_ready);
        end
        if (c == 4) begin
          held_rgb = rgb_out;
          held_sb  = sb_out;
        end else begin
          tests_run++;
          if (rgb_out !== held_rgb || sb_out !== held_sb || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_hold_c%0d: got rgb=%06h sb=%03b valid=%b, expected %06h/%03b/1",
                     c, rgb_out, sb_out, out_valid, held_rgb, held_sb);
          end
        end
      end else if (out_valid === 1'b1) begin
        tests_run++;
        if (rgb_out !== pal_rgb[rx] || sb_out !== 3'(rx)) begin
          tests_failed++;
          $display("FAIL stall_px%0d: got rgb=%06h sb=%0d, expected %06h/%0d",
                   rx, rgb_out, sb_out, pal_rgb[rx], rx);
        end
        rx++;
      end
      if (in_ready === 1'b1 && tx < 6) begin
        drive(pal_h[tx], pal_s[tx], pal_v[tx], 1'b1, 3'(tx));
        tx++;
      end else begin
        drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
      end
      @(negedge clk);
    end
    tests_run++;
    if (rx != 6) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d pixels, expected 6", rx);
    end
    out_ready = 1'b1;
    drain();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_dup: got valid=%b after drain, expected 0", out_valid);
    end
  endtask
`endif

  initial begin
`ifdef HSV2RGB_STALL_EN
    out_ready = 1'b1;
`endif
    rst = 1'b1;
    drive(8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    test_reset();
    test_colors();
    test_grey();
    test_black();
    test_timing();
    test_back_to_back();
    test_mid_reset();
`ifdef HSV2RGB_STALL_EN
    test_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
